// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP16 add/sub issue block and its request queue.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } fpu_state_e;

    localparam logic [15:0] FPU_QNAN       = 16'h7E00;
    localparam logic [2:0]  FPU_TIMEOUT    = 3'd7;
    localparam int          REQ_FIFO_DEPTH = 2;
    localparam int          CNT_W          = $clog2(REQ_FIFO_DEPTH + 1);
    localparam int          REQ_W          = 38;

    typedef struct packed {
        logic        op_sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  rd;
    } fpu_req_t;

    // Subtraction is issued to the adder as a + (-b) by flipping the FP16 sign bit.
    function automatic logic [15:0] fpu_negate(input logic [15:0] x);
        return {~x[15], x[14:0]};
    endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Two-entry request queue; the caller guarantees no push when full and no pop when empty.
module fpu_req_fifo
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [REQ_W-1:0] wdata,
    input  logic             pop,
    output logic [REQ_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [REQ_W-1:0] mem [REQ_FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fpu_add_issue.sv
// Issues queued FP16 add/sub requests to an external adder, with a timeout, and writes results back.
module fpu_add_issue
    import fpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_op_sub,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [4:0]  i_rd,
    output logic        o_stall,
    output logic        o_busy,
    output logic [15:0] o_fpu_a,
    output logic [15:0] o_fpu_b,
    output logic        o_fpu_vld,
    input  logic [15:0] i_fpu_res,
    input  logic        i_fpu_res_vld,
    input  logic        i_fpu_ovf,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd,
    output logic [15:0] o_wb_data,
    output logic        o_wb_ovf,
    output logic        o_err,
    input  logic        i_flag_clr,
    output logic        o_ovf_flag
);

    fpu_state_e       state;
    fpu_state_e       state_nxt;
    logic [2:0]       timer;
    logic [15:0]      data_q;
    logic [4:0]       rd_q;
    logic             ovf_q;
    logic             err_q;
    logic             flag_q;
    logic [CNT_W-1:0] count;
    fpu_req_t         head;
    logic             push;
    logic             pop;
    logic             done;

    // Full stalls even while the head pops, so acceptance never depends on this cycle's pop.
    assign o_stall = (count == CNT_W'(REQ_FIFO_DEPTH));
    assign push    = i_req & ~o_stall;
    assign pop     = (state == ST_WB);
    assign done    = (state == ST_EXEC) & (i_fpu_res_vld | (timer == FPU_TIMEOUT));

    fpu_req_fifo u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .wdata ({i_op_sub, i_a, i_b, i_rd}),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_fpu_vld = 1'b0;
        o_fpu_a   = '0;
        o_fpu_b   = '0;
        o_wb_en   = 1'b0;
        o_wb_ovf  = 1'b0;
        o_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_fpu_vld = 1'b1;
                o_fpu_a   = head.a;
                o_fpu_b   = head.op_sub ? fpu_negate(head.b) : head.b;
                if (done) begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                o_wb_en  = 1'b1;
                o_wb_ovf = ovf_q;
                o_err    = err_q;
                // A push landing alongside the pop also counts as a remaining entry.
                state_nxt = ((count > CNT_W'(1)) || push) ? ST_EXEC : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            timer  <= '0;
            data_q <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            if (state == ST_EXEC) begin
                if (i_fpu_res_vld) begin
                    data_q <= i_fpu_res;
                    ovf_q  <= i_fpu_ovf;
                    err_q  <= 1'b0;
                    rd_q   <= head.rd;
                    timer  <= '0;
                end else if (timer == FPU_TIMEOUT) begin
                    data_q <= FPU_QNAN;
                    ovf_q  <= 1'b0;
                    err_q  <= 1'b1;
                    rd_q   <= head.rd;
                    timer  <= '0;
                end else begin
                    timer <= timer + 3'd1;
                end
            end else begin
                timer <= '0;
            end

            if ((state == ST_WB) && (ovf_q || err_q)) begin
                flag_q <= 1'b1;
            end else if (i_flag_clr) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign o_wb_data  = data_q;
    assign o_wb_rd    = rd_q;
    assign o_ovf_flag = flag_q;
    assign o_busy     = (count != '0) || (state != ST_IDLE);

endmodule
